// File: rtl/arcade_input_pkg.sv
// Shared scan codes, joystick bit layout helpers and coin state type for the arcade input front end.
package arcade_input_pkg;

    localparam logic [8:0] KC_UP_P1        = 9'h175;
    localparam logic [8:0] KC_DOWN_P1      = 9'h172;
    localparam logic [8:0] KC_LEFT_P1      = 9'h16B;
    localparam logic [8:0] KC_RIGHT_P1     = 9'h174;
    localparam logic [8:0] KC_FIRE0_P1     = 9'h014;
    localparam logic [8:0] KC_FIRE1_P1     = 9'h029;
    localparam logic [8:0] KC_FIRE2_P1     = 9'h011;
    localparam logic [8:0] KC_FIRE3_P1     = 9'h012;
    localparam logic [8:0] KC_START_P1     = 9'h005;
    localparam logic [8:0] KC_START_ALT_P1 = 9'h016;
    localparam logic [8:0] KC_COIN_P1      = 9'h02E;

    localparam logic [8:0] KC_UP_P2        = 9'h02D;
    localparam logic [8:0] KC_DOWN_P2      = 9'h02B;
    localparam logic [8:0] KC_LEFT_P2      = 9'h023;
    localparam logic [8:0] KC_RIGHT_P2     = 9'h034;
    localparam logic [8:0] KC_FIRE0_P2     = 9'h01C;
    localparam logic [8:0] KC_FIRE1_P2     = 9'h01B;
    localparam logic [8:0] KC_FIRE2_P2     = 9'h015;
    localparam logic [8:0] KC_FIRE3_P2     = 9'h01D;
    localparam logic [8:0] KC_START_P2     = 9'h006;
    localparam logic [8:0] KC_START_ALT_P2 = 9'h01E;
    localparam logic [8:0] KC_COIN_P2      = 9'h036;

    typedef enum logic [1:0] {
        COIN_IDLE,
        COIN_PULSE,
        COIN_LOCK
    } coin_st_t;

    // slot: 0..3 right/left/down/up, 4..7 fire0..3, 8 start, 9 coin
    typedef struct packed {
        logic       hit;
        logic       player;
        logic [3:0] slot;
    } key_dec_t;

    function automatic int unsigned JOY_FIRE(input int unsigned b);
        return 4 + b;
    endfunction

    function automatic int unsigned JOY_START(input int unsigned buttons);
        return 4 + buttons;
    endfunction

    function automatic int unsigned JOY_COIN(input int unsigned buttons);
        return 5 + buttons;
    endfunction

    function automatic key_dec_t key_decode(input logic [8:0] code);
        key_dec_t d;
        d = '{hit: 1'b1, player: 1'b0, slot: 4'd0};
        case (code)
            KC_RIGHT_P1:                  d.slot = 4'd0;
            KC_LEFT_P1:                   d.slot = 4'd1;
            KC_DOWN_P1:                   d.slot = 4'd2;
            KC_UP_P1:                     d.slot = 4'd3;
            KC_FIRE0_P1:                  d.slot = 4'd4;
            KC_FIRE1_P1:                  d.slot = 4'd5;
            KC_FIRE2_P1:                  d.slot = 4'd6;
            KC_FIRE3_P1:                  d.slot = 4'd7;
            KC_START_P1, KC_START_ALT_P1: d.slot = 4'd8;
            KC_COIN_P1:                   d.slot = 4'd9;
            KC_RIGHT_P2:                  begin d.player = 1'b1; d.slot = 4'd0; end
            KC_LEFT_P2:                   begin d.player = 1'b1; d.slot = 4'd1; end
            KC_DOWN_P2:                   begin d.player = 1'b1; d.slot = 4'd2; end
            KC_UP_P2:                     begin d.player = 1'b1; d.slot = 4'd3; end
            KC_FIRE0_P2:                  begin d.player = 1'b1; d.slot = 4'd4; end
            KC_FIRE1_P2:                  begin d.player = 1'b1; d.slot = 4'd5; end
            KC_FIRE2_P2:                  begin d.player = 1'b1; d.slot = 4'd6; end
            KC_FIRE3_P2:                  begin d.player = 1'b1; d.slot = 4'd7; end
            KC_START_P2, KC_START_ALT_P2: begin d.player = 1'b1; d.slot = 4'd8; end
            KC_COIN_P2:                   begin d.player = 1'b1; d.slot = 4'd9; end
            default:                      d.hit = 1'b0;
        endcase
        return d;
    endfunction

    // Latch bit for a slot, or -1 when that button is not built.
    function automatic int key_bit(input logic [3:0] slot, input int unsigned buttons);
        int s;
        s = int'(slot);
        if (s < 4) return s;
        if (s < 8) return ((s - 4) < int'(buttons)) ? s : -1;
        if (s == 8) return 4 + int'(buttons);
        if (s == 9) return 5 + int'(buttons);
        return -1;
    endfunction

endpackage

// File: rtl/arcade_coin_shaper.sv
// Turns a raw coin request edge into a fixed-length pulse followed by an equal lockout.
module arcade_coin_shaper
    import arcade_input_pkg::*;
#(
    parameter int unsigned CYCLES = 600000
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic req,
    output logic pulse
);

    localparam int unsigned CW = 24;
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    coin_st_t       state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           req_q;
    logic           pulse_nx;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state <= COIN_IDLE;
            cnt   <= '0;
            req_q <= 1'b0;
            pulse <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            req_q <= req;
            pulse <= pulse_nx;
        end
    end

    // Edges outside IDLE are dropped; a held request never retriggers.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            COIN_IDLE: begin
                if (req && !req_q) begin
                    state_nx = COIN_PULSE;
                    cnt_nx   = '0;
                end
            end
            COIN_PULSE: begin
                if (cnt == LAST) begin
                    state_nx = COIN_LOCK;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            COIN_LOCK: begin
                if (cnt == LAST) begin
                    state_nx = COIN_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = COIN_IDLE;
                cnt_nx   = '0;
            end
        endcase
        pulse_nx = (state_nx == COIN_PULSE);
    end

endmodule

// File: rtl/arcade_input_ctrl.sv
// Player input front end: PS/2 key latches merged with joysticks, rotation, SOCD cleaning,
// coin shaping and frame-synchronous autofire.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int unsigned PLAYERS         = 2,
    parameter int unsigned BUTTONS         = 2,
    parameter int unsigned COIN_CYCLES     = 600000,
    parameter int unsigned AUTOFIRE_FRAMES = 3,
    parameter bit          SOCD_CLEAN      = 1'b1
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic [10:0]                  ps2_key,
    input  logic [16*PLAYERS-1:0]        joystick,
    input  logic                         rotate,
    input  logic [PLAYERS-1:0]           autofire_en,
    input  logic                         ce_frame,
    output logic [4*PLAYERS-1:0]         dir,
    output logic [BUTTONS*PLAYERS-1:0]   fire,
    output logic [PLAYERS-1:0]           start,
    output logic [PLAYERS-1:0]           coin
);

    localparam int unsigned KW      = JOY_COIN(BUTTONS) + 1;
    localparam int unsigned KP      = (PLAYERS < 2) ? PLAYERS : 2;
    localparam int unsigned FIRE0   = JOY_FIRE(0);
    localparam int unsigned START_B = JOY_START(BUTTONS);
    localparam int unsigned COIN_B  = JOY_COIN(BUTTONS);

    logic                  tog_q, tog_vld;
    logic [KP-1:0][KW-1:0] key_l, key_d, key_nx;
    key_dec_t              dec;
    logic                  key_ev;

    assign dec    = key_decode(ps2_key[8:0]);
    assign key_ev = tog_vld && (ps2_key[10] != tog_q);

    always_comb begin
        key_nx = key_l;
        for (int p = 0; p < int'(KP); p++) begin
            for (int b = 0; b < int'(KW); b++) begin
                if (key_ev && dec.hit && (dec.player == 1'(p)) &&
                    (key_bit(dec.slot, BUTTONS) == b))
                    key_nx[p][b] = ps2_key[9];
            end
        end
    end

    // tog_vld keeps the first post-reset sample from counting as an event.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q   <= 1'b0;
            tog_vld <= 1'b0;
            key_l   <= '0;
            key_d   <= '0;
        end else begin
            tog_q   <= ps2_key[10];
            tog_vld <= 1'b1;
            key_l   <= key_nx;
            key_d   <= key_l;
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_player
        logic [KW-1:0]      kv, raw;
        logic               up_c, dn_c, lf_c, rt_c;
        logic [3:0]         dir_nx, dir_q;
        logic [BUTTONS-1:0] fire_nx, fire_q;
        logic               start_q;
        logic [3:0]         af_cnt;
        logic               af_ph, af_on;
        logic               unused_joy;

        if (p < KP) begin : g_key
            assign kv = key_d[p];
        end else begin : g_nokey
            assign kv = '0;
        end

        assign raw        = joystick[16*p +: KW] | kv;
        assign af_on      = autofire_en[p] && raw[FIRE0];
        assign unused_joy = ^joystick[16*p+KW +: 16-KW];

        // Rotation happens first so cleaning acts on the displayed axes.
        always_comb begin
            up_c = rotate ? raw[1] : raw[3];
            dn_c = rotate ? raw[0] : raw[2];
            lf_c = rotate ? raw[2] : raw[1];
            rt_c = rotate ? raw[3] : raw[0];
            if (SOCD_CLEAN && up_c && dn_c) begin
                up_c = 1'b0;
                dn_c = 1'b0;
            end
            if (SOCD_CLEAN && lf_c && rt_c) begin
                lf_c = 1'b0;
                rt_c = 1'b0;
            end
            dir_nx     = {up_c, dn_c, lf_c, rt_c};
            fire_nx    = raw[FIRE0 +: BUTTONS];
            fire_nx[0] = raw[FIRE0] && (!autofire_en[p] || af_ph);
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                af_cnt <= '0;
                af_ph  <= 1'b1;
            end else if (!af_on) begin
                af_cnt <= '0;
                af_ph  <= 1'b1;
            end else if (ce_frame) begin
                if (af_cnt == 4'(AUTOFIRE_FRAMES - 1)) begin
                    af_cnt <= '0;
                    af_ph  <= ~af_ph;
                end else begin
                    af_cnt <= af_cnt + 4'd1;
                end
            end
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                dir_q   <= '0;
                fire_q  <= '0;
                start_q <= 1'b0;
            end else begin
                dir_q   <= dir_nx;
                fire_q  <= fire_nx;
                start_q <= raw[START_B];
            end
        end

        assign dir[4*p +: 4]             = dir_q;
        assign fire[BUTTONS*p +: BUTTONS] = fire_q;
        assign start[p]                  = start_q;

        arcade_coin_shaper #(
            .CYCLES (COIN_CYCLES)
        ) u_coin (
            .clk_sys (clk_sys),
            .reset_n (reset_n),
            .req     (raw[COIN_B]),
            .pulse   (coin[p])
        );
    end

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Self-checking bench: constant vector table, hand sequences and randomized run against a cycle model.
module tb_arcade_input_ctrl;

    localparam int C  = 8;
    localparam int AF = 2;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic [31:0] joystick = '0;
    logic        rotate = 1'b0;
    logic [1:0]  autofire_en = '0;
    logic        ce_frame = 1'b0;
    logic [7:0]  dir;
    logic [3:0]  fire;
    logic [1:0]  start;
    logic [1:0]  coin;

    arcade_input_ctrl #(
        .PLAYERS         (2),
        .BUTTONS         (2),
        .COIN_CYCLES     (C),
        .AUTOFIRE_FRAMES (AF),
        .SOCD_CLEAN      (1'b1)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .ps2_key     (ps2_key),
        .joystick    (joystick),
        .rotate      (rotate),
        .autofire_en (autofire_en),
        .ce_frame    (ce_frame),
        .dir         (dir),
        .fire        (fire),
        .start       (start),
        .coin        (coin)
    );

    always #5 clk_sys = ~clk_sys;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Model state: key maps indexed by function (0..3 r/l/d/u, 4..7 fire, 8 start, 9 coin)
    logic [9:0] kq0 [2];
    logic [9:0] kq1 [2];
    logic       tog_m;
    bit         tog_known;
    bit         req_prev [2];
    int         coin_s [2];
    int         frames [2];
    logic [7:0] exp_dir;
    logic [3:0] exp_fire;
    logic [1:0] exp_start, exp_coin;

    typedef struct {
        logic [31:0] joy;
        logic        rot;
        logic [7:0]  dir;
        logic [3:0]  fire;
        logic [1:0]  start;
    } vec_t;

    vec_t       tbl [13];
    logic [8:0] codes [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int decode(input logic [8:0] code);
        case (code)
            9'h174: return 0;   9'h16B: return 1;   9'h172: return 2;   9'h175: return 3;
            9'h014: return 4;   9'h029: return 5;   9'h011: return 6;   9'h012: return 7;
            9'h005, 9'h016: return 8;               9'h02E: return 9;
            9'h034: return 16;  9'h023: return 17;  9'h02B: return 18;  9'h02D: return 19;
            9'h01C: return 20;  9'h01B: return 21;  9'h015: return 22;  9'h01D: return 23;
            9'h006, 9'h01E: return 24;              9'h036: return 25;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            kq0[p] = '0;
            kq1[p] = '0;
            req_prev[p] = 0;
            coin_s[p] = -1000;
            frames[p] = 0;
        end
        tog_known = 0;
        tog_m = 1'b0;
    endtask

    // Expected outputs after the clock edge that samples the current inputs.
    task automatic model_edge();
        logic [9:0] uk [2];
        logic [9:0] nk [2];
        int cr;
        uk = kq1;
        nk = kq0;
        if (!tog_known) begin
            tog_m = ps2_key[10];
            tog_known = 1;
        end else if (ps2_key[10] != tog_m) begin
            tog_m = ps2_key[10];
            cr = decode(ps2_key[8:0]);
            if (cr >= 0) nk[cr / 16][cr % 16] = ps2_key[9];
        end
        kq1 = kq0;
        kq0 = nk;
        for (int p = 0; p < 2; p++) begin
            logic [15:0] j;
            logic ru, rd, rl, rr, u, d, l, r, f0, f1, st, cn, o;
            j  = joystick[16*p +: 16];
            rr = j[0] | uk[p][0];
            rl = j[1] | uk[p][1];
            rd = j[2] | uk[p][2];
            ru = j[3] | uk[p][3];
            if (rotate) begin u = rl; d = rr; l = rd; r = ru; end
            else        begin u = ru; d = rd; l = rl; r = rr; end
            if (u && d) begin u = 0; d = 0; end
            if (l && r) begin l = 0; r = 0; end
            exp_dir[4*p +: 4] = {u, d, l, r};
            f0 = j[4] | uk[p][4];
            f1 = j[5] | uk[p][5];
            st = j[6] | uk[p][8];
            cn = j[7] | uk[p][9];
            if (autofire_en[p] && f0) begin
                o = ((frames[p] / AF) % 2) == 0;
                if (ce_frame) frames[p]++;
            end else begin
                o = f0;
                frames[p] = 0;
            end
            exp_fire[2*p +: 2] = {f1, o};
            exp_start[p] = st;
            if (cn && !req_prev[p] && cyc >= coin_s[p] + 2*C + 1) coin_s[p] = cyc;
            req_prev[p] = cn;
            exp_coin[p] = (cyc >= coin_s[p]) && (cyc < coin_s[p] + C);
        end
        cyc++;
    endtask

    task automatic step();
        @(posedge clk_sys);
        model_edge();
        #1;
        chk("dir",   32'(dir),   32'(exp_dir));
        chk("fire",  32'(fire),  32'(exp_fire));
        chk("start", 32'(start), 32'(exp_start));
        chk("coin",  32'(coin),  32'(exp_coin));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        chk("rst_dir",   32'(dir),   32'h0);
        chk("rst_fire",  32'(fire),  32'h0);
        chk("rst_start", 32'(start), 32'h0);
        chk("rst_coin",  32'(coin),  32'h0);
        model_reset();
        repeat (2) @(posedge clk_sys);
        #1 reset_n = 1'b1;
    endtask

    task automatic send_key(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'h0000_0008, 1'b0, 8'h08, 4'h0, 2'h0};
        tbl[1]  = '{32'h0000_0008, 1'b1, 8'h01, 4'h0, 2'h0};
        tbl[2]  = '{32'h0000_0003, 1'b0, 8'h00, 4'h0, 2'h0};
        tbl[3]  = '{32'h0000_000C, 1'b0, 8'h00, 4'h0, 2'h0};
        tbl[4]  = '{32'h0000_000E, 1'b0, 8'h02, 4'h0, 2'h0};
        tbl[5]  = '{32'h0000_000E, 1'b1, 8'h08, 4'h0, 2'h0};
        tbl[6]  = '{32'h0000_0010, 1'b0, 8'h00, 4'h1, 2'h0};
        tbl[7]  = '{32'h0000_0020, 1'b1, 8'h00, 4'h2, 2'h0};
        tbl[8]  = '{32'h0000_0040, 1'b0, 8'h00, 4'h0, 2'h1};
        tbl[9]  = '{32'h0004_0000, 1'b0, 8'h40, 4'h0, 2'h0};
        tbl[10] = '{32'h0004_0000, 1'b1, 8'h20, 4'h0, 2'h0};
        tbl[11] = '{32'h0001_0008, 1'b1, 8'h41, 4'h0, 2'h0};
        tbl[12] = '{32'h0030_0070, 1'b0, 8'h00, 4'hF, 2'h1};

        codes = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h014, 9'h029, 9'h011, 9'h012,
                  9'h005, 9'h016, 9'h02E, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C,
                  9'h01B, 9'h015, 9'h01D, 9'h006, 9'h01E, 9'h036, 9'h0FF, 9'h100};

        // Mapping, rotation and opposing-direction cleaning
        do_reset();
        step();
        foreach (tbl[i]) begin
            joystick = tbl[i].joy;
            rotate   = tbl[i].rot;
            step();
            chk($sformatf("tbl%0d_dir", i),   32'(dir),   32'(tbl[i].dir));
            chk($sformatf("tbl%0d_fire", i),  32'(fire),  32'(tbl[i].fire));
            chk($sformatf("tbl%0d_start", i), 32'(start), 32'(tbl[i].start));
        end
        joystick = '0;
        rotate   = 1'b0;

        // Key press/release latency and unmapped code
        do_reset();
        repeat (2) step();
        for (int j = 0; j < 14; j++) begin
            if (j == 0)  send_key(1'b1, 9'h175);
            if (j == 10) send_key(1'b0, 9'h175);
            step();
            chk("key_up", 32'(dir[3]), 32'(j >= 2 && j <= 11));
        end
        send_key(1'b1, 9'h0FF);
        for (int j = 0; j < 4; j++) begin
            step();
            chk("unmapped", {dir, fire, start, coin}, 32'h0);
        end

        // Coin pulse, lockout and re-arm
        do_reset();
        repeat (2) step();
        for (int j = 0; j <= 30; j++) begin
            joystick[23] = (j < 11) || (j >= 12 && j < 19) || (j >= 20);
            step();
            chk("coin_p2", 32'(coin[1]), 32'((j < 8) || (j >= 20 && j < 28)));
        end
        joystick = '0;

        // Autofire phase, release and re-press
        do_reset();
        repeat (2) step();
        autofire_en = 2'b01;
        for (int j = 0; j < 44; j++) begin
            joystick[4] = (j != 40);
            ce_frame = (j % 5 == 4) && (j < 40);
            step();
            if (j < 40) chk("af_fire0", 32'(fire[0]), 32'(((j / 5) / 2) % 2 == 0));
            else        chk("af_edge",  32'(fire[0]), 32'(j != 40));
        end
        ce_frame    = 1'b0;
        autofire_en = '0;
        joystick    = '0;
        step();

        // Reset in the middle of a coin pulse with a key held
        do_reset();
        repeat (2) step();
        send_key(1'b1, 9'h175);
        joystick[7] = 1'b1;
        repeat (4) step();
        chk("mid_coin", 32'(coin[0]), 32'h1);
        chk("mid_key",  32'(dir[3]),  32'h1);
        #3;
        joystick = '0;
        do_reset();
        for (int j = 0; j < 5; j++) begin
            step();
            chk("stale_tog", 32'(dir), 32'h0);
        end

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 500; i++) begin
            for (int p = 0; p < 2; p++)
                for (int b = 0; b < 16; b++)
                    if ($urandom_range(0, 11) == 0) joystick[16*p + b] = ~joystick[16*p + b];
            if ($urandom_range(0, 49) == 0) rotate = ~rotate;
            if ($urandom_range(0, 29) == 0) autofire_en = autofire_en ^ 2'($urandom_range(1, 2));
            ce_frame = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) send_key(1'($urandom_range(0, 1)), codes[$urandom_range(0, 23)]);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
